vga_sprite_regs: RTL and testbench

VGA_SPRITE_REGS -- requirements
Module: vga_sprite_regs

---
 rtl/vga_sprite_regs.sv | 206 ++++++++++++++++++++
 tb/tb_vga_sprite_regs.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_regs.sv
// Wishbone register bank for VGA sprite positions: software writes shadow copies,
// and a frame-start pulse atomically publishes them to the active outputs.
module vga_sprite_regs #(
  parameter int NUM_SPRITES = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  input  logic [3:0]                 wb_sel_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_inta_o,
  input  logic                       frame_start_i,
  output logic [NUM_SPRITES*X_W-1:0] sprite_x_o,
  output logic [NUM_SPRITES*Y_W-1:0] sprite_y_o,
  output logic [NUM_SPRITES-1:0]     sprite_vis_o,
  output logic                       commit_o
);

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_STATUS = 6'd1;
  localparam logic [5:0] IDX_COMMIT = 6'd2;
  localparam logic [5:0] SPR_BASE   = 6'd4;
  localparam logic [5:0] SPR_END    = 6'(4 + NUM_SPRITES);

  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_dat;
  logic             r_inta;
  logic             r_commit;
  logic             r_en;
  logic             r_irqEn;
  logic             r_autoCommit;
  logic             r_irqPending;
  logic             r_commitPending;
  logic [15:0]      r_frameCount;
  logic [X_W-1:0]   r_shX   [NUM_SPRITES];
  logic [Y_W-1:0]   r_shY   [NUM_SPRITES];
  logic             r_shVis [NUM_SPRITES];
  logic [X_W-1:0]   r_actX  [NUM_SPRITES];
  logic [Y_W-1:0]   r_actY  [NUM_SPRITES];
  logic             r_actVis[NUM_SPRITES];

  logic             w_req;
  logic             w_valid;
  logic             w_wr;
  logic [5:0]       w_idx;
  logic [31:0]      w_mask;
  logic [31:0]      w_rdata;
  logic [31:0]      w_ctrlWord;
  logic [31:0]      w_sprWord [NUM_SPRITES];
  logic             w_commitNow;
  logic             w_enNxt;
  logic             w_irqEnNxt;
  logic             w_autoNxt;
  logic             w_irqPendingNxt;
  logic             w_commitPendingNxt;
  logic             w_unused;

  function automatic logic [31:0] packSprite(input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y,
                                             input logic           vis);
    logic [31:0] word;
    word           = '0;
    word[X_W-1:0]  = x;
    word[16 +: Y_W] = y;
    word[31]       = vis;
    return word;
  endfunction

  // A request is only taken while no response is being presented, giving one wait state.
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_idx   = wb_adr_i[7:2];
  assign w_valid = (w_idx == IDX_CTRL) || (w_idx == IDX_STATUS) || (w_idx == IDX_COMMIT) ||
                   ((w_idx >= SPR_BASE) && (w_idx < SPR_END));
  assign w_wr    = w_req & w_valid & wb_we_i;
  assign w_mask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      IDX_CTRL:   w_rdata = {29'd0, r_autoCommit, r_irqEn, r_en};
      IDX_STATUS: w_rdata = {r_frameCount, 14'd0, r_commitPending, r_irqPending};
      default: begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (w_idx == SPR_BASE + 6'(i)) begin
            w_rdata = packSprite(r_shX[i], r_shY[i], r_shVis[i]);
          end
        end
      end
    endcase
  end

  always_comb begin
    w_ctrlWord = ({29'd0, r_autoCommit, r_irqEn, r_en} & ~w_mask) | (wb_dat_i & w_mask);
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_sprWord[i] = (packSprite(r_shX[i], r_shY[i], r_shVis[i]) & ~w_mask) |
                     (wb_dat_i & w_mask);
    end
  end

  // Commit decisions use pre-write state so a same-edge write lands after the copy.
  always_comb begin
    w_enNxt            = r_en;
    w_irqEnNxt         = r_irqEn;
    w_autoNxt          = r_autoCommit;
    w_commitNow        = frame_start_i & r_en & (r_commitPending | r_autoCommit);
    w_commitPendingNxt = r_commitPending;
    w_irqPendingNxt    = r_irqPending;

    if (w_wr && (w_idx == IDX_CTRL)) begin
      {w_autoNxt, w_irqEnNxt, w_enNxt} = w_ctrlWord[2:0];
    end

    if (w_commitNow) begin
      w_commitPendingNxt = 1'b0;
    end
    if (w_wr && (w_idx == IDX_COMMIT) && (|wb_sel_i)) begin
      w_commitPendingNxt = 1'b1;
    end

    if (w_wr && (w_idx == IDX_STATUS) && wb_sel_i[0] && wb_dat_i[0]) begin
      w_irqPendingNxt = 1'b0;
    end
    if (w_commitNow && r_irqEn) begin
      w_irqPendingNxt = 1'b1;
    end
  end

  always_comb begin
    w_unused = ^{wb_adr_i[31:8], wb_adr_i[1:0], w_ctrlWord[31:3]};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_unused = w_unused ^ (^w_sprWord[i]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack           <= 1'b0;
      r_err           <= 1'b0;
      r_dat           <= '0;
      r_inta          <= 1'b0;
      r_commit        <= 1'b0;
      r_en            <= 1'b0;
      r_irqEn         <= 1'b0;
      r_autoCommit    <= 1'b0;
      r_irqPending    <= 1'b0;
      r_commitPending <= 1'b0;
      r_frameCount    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shX[i]    <= '0;
        r_shY[i]    <= '0;
        r_shVis[i]  <= 1'b0;
        r_actX[i]   <= '0;
        r_actY[i]   <= '0;
        r_actVis[i] <= 1'b0;
      end
    end else begin
      r_ack           <= w_req & w_valid;
      r_err           <= w_req & ~w_valid;
      r_dat           <= (w_req && w_valid) ? w_rdata : '0;
      r_en            <= w_enNxt;
      r_irqEn         <= w_irqEnNxt;
      r_autoCommit    <= w_autoNxt;
      r_irqPending    <= w_irqPendingNxt;
      r_commitPending <= w_commitPendingNxt;
      r_inta          <= w_irqPendingNxt & w_irqEnNxt;
      r_commit        <= w_commitNow;
      if (frame_start_i) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_commitNow) begin
          r_actX[i]   <= r_shX[i];
          r_actY[i]   <= r_shY[i];
          r_actVis[i] <= r_shVis[i];
        end
        if (w_wr && (w_idx == SPR_BASE + 6'(i))) begin
          r_shX[i]   <= w_sprWord[i][X_W-1:0];
          r_shY[i]   <= w_sprWord[i][16 +: Y_W];
          r_shVis[i] <= w_sprWord[i][31];
        end
      end
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_dat_o  = r_dat;
  assign wb_inta_o = r_inta;
  assign commit_o  = r_commit;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    assign sprite_x_o[g*X_W +: X_W] = r_actX[g];
    assign sprite_y_o[g*Y_W +: Y_W] = r_actY[g];
    assign sprite_vis_o[g]          = r_actVis[g];
  end

endmodule

// File: tb/tb_vga_sprite_regs.sv
// Bench for vga_sprite_regs: a word-level register model is compared against the
// DUT every cycle, plus hand-computed spot values from directed bus sequences.
module tb_vga_sprite_regs;

  localparam int NS = 4;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam logic [31:0] SPR_MASK = 32'h83FF_03FF;

  logic            clk = 1'b0;
  logic            wb_rst_i, wb_cyc_i, wb_stb_i, wb_we_i, frame_start_i;
  logic [31:0]     wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]      wb_sel_i;
  logic            wb_ack_o, wb_err_o, wb_inta_o, commit_o;
  logic [NS*XW-1:0] sprite_x_o;
  logic [NS*YW-1:0] sprite_y_o;
  logic [NS-1:0]    sprite_vis_o;

  always #5 clk = ~clk;

  vga_sprite_regs #(.NUM_SPRITES(NS), .X_W(XW), .Y_W(YW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_inta_o(wb_inta_o),
    .frame_start_i(frame_start_i), .sprite_x_o(sprite_x_o), .sprite_y_o(sprite_y_o),
    .sprite_vis_o(sprite_vis_o), .commit_o(commit_o)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register model: every register kept as a plain 32-bit word.
  logic [31:0] mCtrl, mRdata, mMask, mRdNext;
  logic [31:0] mShadow [NS];
  logic [31:0] mActive [NS];
  logic [15:0] mFc;
  logic        mIrq, mPend, mAck, mErr, mInta, mCommit, mRdCheck;
  logic        mAcc, mValid, mWr, mCommitNow;
  int          mIdx;

  always @(posedge clk) begin
    if (wb_rst_i) begin
      mCtrl = 0; mIrq = 0; mPend = 0; mFc = 0; mAck = 0; mErr = 0;
      mInta = 0; mCommit = 0; mRdata = 0; mRdCheck = 0;
      for (int i = 0; i < NS; i++) begin mShadow[i] = 0; mActive[i] = 0; end
    end else begin
      mIdx   = int'(wb_adr_i[7:2]);
      mAcc   = wb_cyc_i && wb_stb_i && !mAck && !mErr;
      mValid = (mIdx <= 2) || (mIdx >= 4 && mIdx < 4 + NS);
      mWr    = mAcc && mValid && wb_we_i;
      mMask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
      mRdNext = 0;
      if (mAcc && mValid) begin
        if (mIdx == 0) mRdNext = mCtrl;
        else if (mIdx == 1) mRdNext = {mFc, 14'd0, mPend, mIrq};
        else if (mIdx >= 4) mRdNext = mShadow[mIdx-4];
      end
      mCommitNow = frame_start_i && mCtrl[0] && (mPend || mCtrl[2]);
      if (mCommitNow) begin
        for (int i = 0; i < NS; i++) mActive[i] = mShadow[i];
        mPend = 0;
      end
      if (mWr && mIdx == 2 && wb_sel_i != 0) mPend = 1;
      if (mCommitNow && mCtrl[1]) mIrq = 1;
      else if (mWr && mIdx == 1 && wb_sel_i[0] && wb_dat_i[0]) mIrq = 0;
      if (mWr && mIdx == 0) mCtrl = ((mCtrl & ~mMask) | (wb_dat_i & mMask)) & 32'h7;
      if (mWr && mIdx >= 4)
        mShadow[mIdx-4] = ((mShadow[mIdx-4] & ~mMask) | (wb_dat_i & mMask)) & SPR_MASK;
      if (frame_start_i) mFc = mFc + 16'd1;
      mAck     = mAcc && mValid;
      mErr     = mAcc && !mValid;
      mRdCheck = mAcc && mValid && !wb_we_i;
      mRdata   = mRdNext;
      mCommit  = mCommitNow;
      mInta    = mIrq && mCtrl[1];
    end
  end

  logic [NS*XW-1:0] expX;
  logic [NS*YW-1:0] expY;
  logic [NS-1:0]    expV;

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < NS; i++) begin
        expX[i*XW +: XW] = mActive[i][XW-1:0];
        expY[i*YW +: YW] = mActive[i][16 +: YW];
        expV[i]          = mActive[i][31];
      end
      checkOutput("ack", wb_ack_o, mAck);
      checkOutput("err", wb_err_o, mErr);
      if (mRdCheck) checkOutput("rdata", wb_dat_o, mRdata);
      if (mErr) checkOutput("err_data", wb_dat_o, 0);
      checkOutput("inta", wb_inta_o, mInta);
      checkOutput("commit", commit_o, mCommit);
      checkOutput("sprite_x", sprite_x_o, expX);
      checkOutput("sprite_y", sprite_y_o, expY);
      checkOutput("sprite_vis", sprite_vis_o, expV);
    end
  end

  // Bus transaction; entered and left on a falling edge. fs raises frame_start_i on the accept edge.
  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                               input logic [3:0] sel, input logic fs,
                               output logic [31:0] rd, output logic gotErr);
    int n;
    if (fs && (wb_ack_o || wb_err_o)) begin
      wb_cyc_i = 0; wb_stb_i = 0;
      @(negedge clk);
    end
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; frame_start_i = fs;
    n = 0;
    do begin
      @(negedge clk);
      frame_start_i = 0;
      n++;
    end while (!(wb_ack_o || wb_err_o) && n < 8);
    rd = wb_dat_o;
    gotErr = wb_err_o;
    if (!(wb_ack_o || wb_err_o)) begin
      checks++; errors++;
      $display("[TB] FAIL bus_timeout: got no response expected ack or err at adr 0x%0h", adr);
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic pulseFrame();
    frame_start_i = 1;
    @(negedge clk);
    frame_start_i = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          seen;
  int          n;

  initial begin
    wb_rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; frame_start_i = 0;
    repeat (2) @(negedge clk);
    checkEn = 1;
    wb_rst_i = 0;
    checkOutput("rst_ack", wb_ack_o, 0);
    checkOutput("rst_dat", wb_dat_o, 0);
    checkOutput("rst_x", sprite_x_o, 0);
    checkOutput("rst_inta", wb_inta_o, 0);

    // Basic commit with interrupt
    applyStimulus(32'h00, 1, 32'h3, 4'hF, 0, rd, er);
    applyStimulus(32'h10, 1, 32'h8195_0125, 4'hF, 0, rd, er);
    applyStimulus(32'h08, 1, 32'h1, 4'hF, 0, rd, er);
    pulseFrame();
    checkOutput("c32_x0", sprite_x_o[9:0], 10'h125);
    checkOutput("c32_y0", sprite_y_o[9:0], 10'h195);
    checkOutput("c32_vis0", sprite_vis_o[0], 1);
    checkOutput("c32_commit", commit_o, 1);
    checkOutput("c32_inta", wb_inta_o, 1);
    @(negedge clk);
    checkOutput("c32_commit_drop", commit_o, 0);
    applyStimulus(32'h04, 1, 32'h1, 4'hF, 0, rd, er);
    checkOutput("c32_inta_clr", wb_inta_o, 0);

    // Byte-lane write into shadow only
    applyStimulus(32'h14, 1, 32'h0000_0300, 4'hF, 0, rd, er);
    applyStimulus(32'h14, 1, 32'hFFFF_FFAA, 4'b0001, 0, rd, er);
    applyStimulus(32'h14, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("c33_readback", rd, 32'h0000_03AA);
    checkOutput("c33_active_old", sprite_x_o[19:10], 0);
    applyStimulus(32'h08, 1, 32'h1, 4'h2, 0, rd, er);
    pulseFrame();
    checkOutput("c33_active_new", sprite_x_o[19:10], 10'h3AA);
    applyStimulus(32'h04, 1, 32'h1, 4'h1, 0, rd, er);

    // Decode errors
    applyStimulus(32'h20, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("c34_err20", er, 1);
    checkOutput("c34_dat20", rd, 0);
    applyStimulus(32'h0C, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("c34_err0c", er, 1);
    applyStimulus(32'h20, 1, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    applyStimulus(32'h1C, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("c34_ack1c", er, 0);
    checkOutput("c34_dat1c", rd, 0);
    applyStimulus(32'h00, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("c34_ctrl_kept", rd, 32'h3);

    // Write coinciding with an auto-commit frame
    applyStimulus(32'h00, 1, 32'h7, 4'hF, 0, rd, er);
    applyStimulus(32'h18, 1, 32'h8001_0002, 4'hF, 0, rd, er);
    applyStimulus(32'h18, 1, 32'h0005_0006, 4'hF, 1, rd, er);
    checkOutput("c35_x_old", sprite_x_o[29:20], 10'h002);
    checkOutput("c35_y_old", sprite_y_o[29:20], 10'h001);
    checkOutput("c35_vis_old", sprite_vis_o[2], 1);
    pulseFrame();
    checkOutput("c35_x_new", sprite_x_o[29:20], 10'h006);
    checkOutput("c35_y_new", sprite_y_o[29:20], 10'h005);
    checkOutput("c35_vis_new", sprite_vis_o[2], 0);

    // irq set wins over same-edge clear
    applyStimulus(32'h04, 1, 32'h1, 4'hF, 1, rd, er);
    checkOutput("irq_set_wins", wb_inta_o, 1);
    applyStimulus(32'h04, 1, 32'h1, 4'hF, 0, rd, er);
    checkOutput("irq_cleared", wb_inta_o, 0);

    // COMMIT write on a commit frame keeps pending
    applyStimulus(32'h00, 1, 32'h3, 4'hF, 0, rd, er);
    applyStimulus(32'h08, 1, 32'h1, 4'hF, 0, rd, er);
    applyStimulus(32'h08, 1, 32'h1, 4'hF, 1, rd, er);
    checkOutput("pend_commit_pulse", commit_o, 1);
    applyStimulus(32'h04, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("pend_kept", rd & 32'h3, 32'h3);

    // Reset in the middle of a request aborts it; the retry completes
    wb_rst_i = 1; wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    wb_adr_i = 32'h00; wb_dat_i = 32'h5; wb_sel_i = 4'hF;
    @(negedge clk);
    checkOutput("rst_abort_ack", wb_ack_o, 0);
    checkOutput("rst_abort_err", wb_err_o, 0);
    wb_rst_i = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    checkOutput("rst_retry_ack", wb_ack_o, 1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    applyStimulus(32'h00, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("rst_retry_ctrl", rd, 32'h5);

    // Frame counter wrap with commits disabled
    applyStimulus(32'h00, 1, 32'h0, 4'hF, 0, rd, er);
    applyStimulus(32'h08, 1, 32'h1, 4'hF, 0, rd, er);
    seen = 0;
    frame_start_i = 1;
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk);
      if (commit_o) seen++;
    end
    frame_start_i = 0;
    checkOutput("wrap_no_commit", seen, 0);
    applyStimulus(32'h04, 0, 32'h0, 4'hF, 0, rd, er);
    checkOutput("wrap_status", rd, 32'h0000_0002);
    applyStimulus(32'h00, 1, 32'h1, 4'hF, 0, rd, er);
    @(negedge clk);
    pulseFrame();
    checkOutput("wrap_late_commit", commit_o, 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
